// File: rtl/se_pkg.sv
// Shared types and arithmetic helpers for the squeeze-excitation FC stages.
package se_pkg;

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    EMIT
  } se_state_e;

  localparam int unsigned SE_FRAC_BITS = 8;

  function automatic int unsigned acc_width(int unsigned dw, int unsigned c_in);
    return 2 * dw + $clog2(c_in) + 1;
  endfunction

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic longint saturate(longint v, int unsigned dw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/se_coef_ram.sv
// Coefficient store: synchronous write, combinational read, contents kept across reset.
module se_coef_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/se_fc_reduce.sv
// SE reduce stage (FC1): serial C_IN-wide input vector, C_OUT biased dot products,
// one MAC per cycle, saturated results emitted as single-cycle pulses.
module se_fc_reduce
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = SE_FRAC_BITS,
  parameter int C_IN       = 16,
  parameter int C_OUT      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                wt_we,
  input  logic [$clog2(C_IN*C_OUT)-1:0]       wt_addr,
  input  logic signed [DATA_WIDTH-1:0]        wt_data,
  input  logic                                bias_we,
  input  logic [$clog2(C_OUT)-1:0]            bias_addr,
  input  logic signed [DATA_WIDTH-1:0]        bias_data,
  output logic signed [DATA_WIDTH-1:0]        out_data,
  output logic                                out_valid,
  output logic                                done
);

  localparam int ACC_W = acc_width(DATA_WIDTH, C_IN);
  localparam int WA_W  = $clog2(C_IN * C_OUT);
  localparam int CI_W  = $clog2(C_IN);
  localparam int CO_W  = $clog2(C_OUT);
  localparam int PW    = 2 * DATA_WIDTH;

  se_state_e                     state_q;
  logic [CI_W-1:0]               cnt_q;
  logic [CI_W-1:0]               i_q;
  logic [CO_W-1:0]               o_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [ACC_W-1:0]       acc_d;
  logic signed [ACC_W-1:0]       bias_ext;
  logic signed [DATA_WIDTH-1:0]  out_data_q;
  logic                          out_valid_q;
  logic                          done_q;
  logic                          in_ready_q;
  logic signed [DATA_WIDTH-1:0]  buf_q [C_IN];

  logic [WA_W-1:0]               wt_raddr;
  logic [CO_W-1:0]               bias_raddr;
  logic signed [DATA_WIDTH-1:0]  wt_rd;
  logic signed [DATA_WIDTH-1:0]  bias_rd;
  logic signed [PW-1:0]          prod;
  logic                          coef_wr_ok;

  assign coef_wr_ok = (state_q == LOAD);
  assign wt_raddr   = WA_W'(o_q) * WA_W'(C_IN) + WA_W'(i_q);
  assign bias_raddr = (state_q == EMIT) ? o_q + CO_W'(1) : '0;

  se_coef_ram #(.WIDTH(DATA_WIDTH), .DEPTH(C_IN * C_OUT), .AW(WA_W)) u_wt_ram (
    .clk     (clk),
    .we_i    (wt_we && coef_wr_ok),
    .waddr_i (wt_addr),
    .wdata_i (wt_data),
    .raddr_i (wt_raddr),
    .rdata_o (wt_rd)
  );

  se_coef_ram #(.WIDTH(DATA_WIDTH), .DEPTH(C_OUT), .AW(CO_W)) u_bias_ram (
    .clk     (clk),
    .we_i    (bias_we && coef_wr_ok),
    .waddr_i (bias_addr),
    .wdata_i (bias_data),
    .raddr_i (bias_raddr),
    .rdata_o (bias_rd)
  );

  assign prod     = PW'(buf_q[i_q]) * PW'(wt_rd);
  assign acc_d    = acc_q + ACC_W'(prod);
  assign bias_ext = {{(ACC_W - DATA_WIDTH - FRAC_BITS){bias_rd[DATA_WIDTH-1]}},
                     bias_rd, {FRAC_BITS{1'b0}}};

  always_ff @(posedge clk) begin
    if (in_valid && in_ready_q) buf_q[cnt_q] <= in_data;
  end

  // Output registers load from the final MAC cycle's sum, so the pulse is
  // visible during the EMIT cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      i_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            if (cnt_q == CI_W'(C_IN - 1)) begin
              state_q    <= MAC;
              i_q        <= '0;
              o_q        <= '0;
              acc_q      <= bias_ext;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CI_W'(1);
            end
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (i_q == CI_W'(C_IN - 1)) begin
            i_q         <= '0;
            state_q     <= EMIT;
            out_data_q  <= DATA_WIDTH'(saturate(longint'(acc_d >>> FRAC_BITS), DATA_WIDTH));
            out_valid_q <= 1'b1;
            done_q      <= (o_q == CO_W'(C_OUT - 1));
          end else begin
            i_q <= i_q + CI_W'(1);
          end
        end
        EMIT: begin
          if (o_q != CO_W'(C_OUT - 1)) begin
            o_q     <= o_q + CO_W'(1);
            acc_q   <= bias_ext;
            state_q <= MAC;
          end else begin
            cnt_q      <= '0;
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_se_fc_reduce.sv
// Scoreboard bench for se_fc_reduce (C_IN=4, C_OUT=2) against a plain-arithmetic model.
module tb_se_fc_reduce;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int CI = 4;
  localparam int CO = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 wt_we;
  logic [2:0]           wt_addr;
  logic signed [DW-1:0] wt_data;
  logic                 bias_we;
  logic [0:0]           bias_addr;
  logic signed [DW-1:0] bias_data;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  se_fc_reduce #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .C_IN(CI), .C_OUT(CO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .bias_we   (bias_we),
    .bias_addr (bias_addr),
    .bias_data (bias_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  logic signed [DW-1:0] Wm  [CI*CO];
  logic signed [DW-1:0] Bm  [CO];
  logic signed [DW-1:0] vec [CI];

  // Reference: real-valued dot product plus bias, floored to the fixed-point grid, clamped.
  function automatic logic [15:0] ref_out(int o);
    longint acc;
    acc = longint'(Bm[o]) * 256;
    for (int i = 0; i < CI; i++) acc += longint'(vec[i]) * longint'(Wm[o*CI+i]);
    acc = acc >>> FB;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  exp_t e;
  always @(negedge clk) begin
    if (done) begin
      n_tests++;
      if (!out_valid) begin
        n_fail++;
        $display("FAIL done_without_valid cyc=%0d got done=1 out_valid=0, need out_valid=1", cyc);
      end
    end
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out cyc=%0d got out_valid=1 data=%h, need no output", cyc, out_data);
      end else begin
        e = sbq.pop_front();
        n_tests += 3;
        if (out_data !== e.data) begin
          n_fail++;
          $display("FAIL out_data cyc=%0d got %h need %h", cyc, out_data, e.data);
        end
        if (done !== e.last) begin
          n_fail++;
          $display("FAIL done_flag cyc=%0d got %b need %b", cyc, done, e.last);
        end
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out_timing got cycle %0d need cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %h need %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_ready;
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      tick;
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout cyc=%0d got in_ready=0 need 1 within 200 cycles", cyc);
    end
  endtask

  task automatic write_w(int a, logic [15:0] d);
    wait_ready;
    wt_we = 1'b1; wt_addr = 3'(a); wt_data = d;
    if (in_ready) Wm[a] = d;
    tick;
    wt_we = 1'b0;
  endtask

  task automatic write_b(int a, logic [15:0] d);
    wait_ready;
    bias_we = 1'b1; bias_addr = 1'(a); bias_data = d;
    if (in_ready) Bm[a] = d;
    tick;
    bias_we = 1'b0;
  endtask

  task automatic set_all(logic [15:0] w, logic [15:0] b);
    for (int a = 0; a < CI*CO; a++) write_w(a, w);
    for (int a = 0; a < CO; a++) write_b(a, b);
  endtask

  task automatic send_vec(bit push, bit gaps, output int t);
    t = 0;
    wait_ready;
    for (int b = 0; b < CI; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      chk("in_ready_at_beat", 32'(in_ready), 32'd1);
      in_data = vec[b];
      in_valid = 1'b1;
      if (b == CI - 1) t = cyc;
      tick;
      in_valid = 1'b0;
    end
    if (push)
      for (int o = 0; o < CO; o++)
        sbq.push_back('{ref_out(o), (o == CO - 1), t + (o + 1) * (CI + 1)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; in_data = '0; in_valid = 1'b0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    bias_we = 1'b0; bias_addr = '0; bias_data = '0;
    repeat (3) tick;
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick;

    // 1: unit weights
    set_all(16'h0100, 16'h0000);
    vec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(1, 1, t);
    // 2: negative weights, half bias
    set_all(16'hFF00, 16'h0080);
    send_vec(1, 1, t);
    // 3: saturation both ways
    set_all(16'h7FFF, 16'h0000);
    vec = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    send_vec(1, 0, t);
    set_all(16'h8001, 16'h0000);
    send_vec(1, 0, t);
    // 4: floor truncation
    set_all(16'h0000, 16'h0000);
    write_w(0, 16'h0001);
    write_w(4, 16'hFFFF);
    vec = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    send_vec(1, 1, t);

    // 5: busy-phase input and write attempts are ignored
    set_all(16'h0100, 16'h0000);
    vec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(1, 0, t);
    for (int c = 1; c <= 10; c++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      wt_we    = (c <= 9);
      wt_addr  = 3'(c - 1);
      wt_data  = '0;
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      tick;
    end
    in_valid = 1'b0;
    wt_we = 1'b0;
    chk("in_ready_after_emit", 32'(in_ready), 32'd1);
    send_vec(1, 1, t);

    // 6: reset in the middle of MAC
    send_vec(0, 0, t);
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (15) tick;
    chk("midrst_idle_ready", 32'(in_ready), 32'd1);
    send_vec(1, 1, t);

    // Random coefficients and inputs
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < CI*CO; a++)
        write_w(a, (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512));
      for (int a = 0; a < CO; a++) write_b(a, 16'($urandom));
      for (int b = 0; b < CI; b++)
        vec[b] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      send_vec(1, 1, t);
    end

    wait_ready;
    repeat (5) tick;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/se_fc_reduce.md
Name: se_fc_reduce

Overview:
Squeeze-excitation reduce stage (FC1) of the SE layer. It collects C_IN globally pooled channel values serially and computes C_OUT fixed-point dot products with bias, using one MAC per cycle. Results are emitted serially as single-cycle valid pulses straight into the downstream ReLU stage, which has no backpressure. Weights and biases are loaded through a write port while the block is idle.

Parameters:
- DATA_WIDTH, 16: signed width of activations, weights, biases and outputs.
- FRAC_BITS, 8: fractional bits. All operands are signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- C_IN, 16: number of input channels (squeeze length).
- C_OUT, 4: number of output channels (C_IN/4 reduction).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  signed pooled activation.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts input; high only in LOAD state.
- wt_we  in  1  weight write strobe.
- wt_addr  in  clog2(C_IN*C_OUT)  weight index = o*C_IN + i.
- wt_data  in  DATA_WIDTH  signed weight.
- bias_we  in  1  bias write strobe.
- bias_addr  in  clog2(C_OUT)  bias index o.
- bias_data  in  DATA_WIDTH  signed bias.
- out_data  out  DATA_WIDTH  signed saturated FC result (feeds ReLU in_data).
- out_valid  out  1  one-cycle pulse per output channel.
- done  out  1  one-cycle pulse, coincident with the last out_valid of a vector.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears state to LOAD, all counters, accumulator, out_data=0, out_valid=0, done=0. After reset, in_ready=1.
- Weight and bias arrays are NOT reset; their contents survive rst.
- State LOAD:
  - A beat transfers when in_valid && in_ready. The beat is stored to input buffer[cnt] and cnt increments.
  - On the C_IN-th transfer (cycle T): go to MAC, with o=0, i=0, acc = sign-extended bias[0] << FRAC_BITS.
- State MAC:
  - Each cycle: acc += buffer[i]*W[o*C_IN+i]; i increments.
  - After C_IN cycles, go to EMIT.
  - in_ready=0; in_valid is ignored and no data is captured.
- State EMIT (1 cycle):
  - out_data = sat(acc >>> FRAC_BITS), out_valid=1.
  - If o<C_OUT-1: o increments, acc reloads with bias[o+1]<<FRAC_BITS, go to MAC.
  - Else: done=1, cnt=0, go to LOAD.
- Latency: out_valid for channel o is asserted in cycle T + (o+1)*(C_IN+1). in_ready returns high in the cycle after the final EMIT.
- Arithmetic:
  - Product is 2*DATA_WIDTH signed.
  - Accumulator ACC_W = 2*DATA_WIDTH + clog2(C_IN) + 1 bits, so it never overflows.
  - Right shift is arithmetic (floor, no rounding).
  - Saturation limits: [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Weight/bias writes: accepted only in LOAD, one entry per cycle. Writes in MAC or EMIT are ignored. Simultaneous wt_we and bias_we in LOAD are both performed.
- Input beats during LOAD may arrive with gaps. Partial vectors persist until completed or until reset.
- Reset mid-operation (any state): returns to LOAD with no further out_valid or done. Any partial vector is discarded.

Decomposition:
- Package se_pkg holds:
  - the state enum (LOAD, MAC, EMIT);
  - the FRAC_BITS default and the ACC_W computation function;
  - the saturate(acc) function, shared with other SE FC stages.
- One sub-module, se_coef_ram: synchronous-write, combinational-read array with no reset. It is instantiated twice, once for weights and once for biases.

Test Plan (bench overrides C_IN=4, C_OUT=2):
1. All weights 0x0100, biases 0; inputs 0x0100, 0x0200, 0x0300, 0x0400 -> out_data 0x0A00 twice. Pulses at T+5 and T+10; done with the second pulse.
2. All weights 0xFF00, biases 0x0080; same inputs -> 0xF680 (-9.5) on both outputs.
3. All weights 0x7FFF, inputs 0x7FFF -> 0x7FFF. Negate the weights to 0x8001 -> 0x8000 (saturation both ways).
4. Truncation check:
   - W[0]=0x0001, W[4]=0xFFFF, all other weights 0, biases 0; inputs 0x0001, 0, 0, 0.
   - Expected: out0=0x0000 (1>>>8), out1=0xFFFF (-1>>>8).
5. Busy-phase robustness:
   - Hold in_valid=1 with changing data through MAC/EMIT, and pulse wt_we writing 0 to all weights during MAC.
   - Expected: in_ready=0 throughout, results identical to Test 1, weights unchanged on the next run.
6. Assert rst for one cycle at T+3 of a Test 1 run:
   - no out_valid or done afterwards; in_ready=1 after reset release.
   - Re-sending the inputs without reloading weights gives 0x0A00 twice.
